// File: rtl/watch_pkg.sv
// Shared types and default timing for the watch front-panel controller.
// State encoding, display field codes and helpers used by watch_set_ctrl.
package watch_pkg;

    typedef enum logic [1:0] {
        TIMER      = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MINUTE = 2'b10
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_MIN  = 2'b01;
    localparam logic [1:0] FIELD_HOUR = 2'b10;

    localparam int unsigned DEF_DEBOUNCE_CNT  = 32'd1000000;
    localparam int unsigned DEF_BLINK_CNT     = 32'd26214400;
    localparam int unsigned DEF_REPEAT_DELAY  = 32'd26214400;
    localparam int unsigned DEF_REPEAT_PERIOD = 32'd10485760;

    function automatic state_t next_mode(input state_t s);
        case (s)
            TIMER:      return SET_HOUR;
            SET_HOUR:   return SET_MINUTE;
            SET_MINUTE: return TIMER;
            default:    return TIMER;
        endcase
    endfunction

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            TIMER:      return FIELD_NONE;
            SET_HOUR:   return FIELD_HOUR;
            SET_MINUTE: return FIELD_MIN;
            default:    return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge press detect
// for one raw push-button.
import watch_pkg::*;

module key_debounce #(
    parameter int unsigned DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          level_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept a new level only after an unbroken run of disagreement
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            level_d_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r   <= key;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;
    assign press = level_r & ~level_d_r;

endmodule

// File: rtl/watch_set_ctrl.sv
// Front-panel controller: debounced mode/inc keys drive the Timer/Set-Hour/
// Set-Minute machine. Define WATCH_SET_AUTOREPEAT_EN to enable inc auto-repeat.
import watch_pkg::*;

module watch_set_ctrl #(
    parameter int unsigned DEBOUNCE_CNT  = DEF_DEBOUNCE_CNT,
    parameter int unsigned BLINK_CNT     = DEF_BLINK_CNT,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       mode,
    output logic       minute_set,
    output logic       hour_set,
    output logic [1:0] set_field,
    output logic       blink
);

    localparam int BW = $clog2(BLINK_CNT + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

    logic   mode_level;
    logic   mode_press;
    logic   inc_level;
    logic   inc_press;
    logic   rep_fire;
    logic   inc_fire;
    logic   in_set;
    logic   unused_levels;
    state_t state_r;
    state_t state_nxt;
    logic [BW-1:0] blink_cnt_r;
    logic   blink_r;

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_mode_key (
        .clock (clock),
        .reset (reset),
        .key   (key_mode),
        .level (mode_level),
        .press (mode_press)
    );

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_inc_key (
        .clock (clock),
        .reset (reset),
        .key   (key_inc),
        .level (inc_level),
        .press (inc_press)
    );

    assign unused_levels = mode_level ^ inc_level;
    assign in_set        = (state_r != TIMER);
    // A mode event always wins over a same-cycle increment
    assign inc_fire      = in_set & ~mode_press & (inc_press | rep_fire);

    // Mode state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= TIMER;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state: each mode event advances one step around the ring
    always_comb begin
        state_nxt = state_r;
        if (mode_press) begin
            state_nxt = next_mode(state_r);
        end else begin
            state_nxt = state_r;
        end
    end

`ifdef WATCH_SET_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_ONE     = RW'(1);

    logic [RW-1:0] rep_cnt_r;
    logic          rep_active_r;
    logic          rep_first_r;

    // First repeat waits the long delay, later ones the shorter period
    always_comb begin
        rep_fire = 1'b0;
        if (rep_first_r) begin
            rep_fire = rep_active_r & inc_level & (rep_cnt_r == DELAY_LAST);
        end else begin
            rep_fire = rep_active_r & inc_level & (rep_cnt_r == PERIOD_LAST);
        end
    end

    // Repeat timer armed by a press in a set state, dropped on release or state change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt_r    <= '0;
            rep_active_r <= 1'b0;
            rep_first_r  <= 1'b0;
        end else if (mode_press || !in_set || !inc_level) begin
            rep_cnt_r    <= '0;
            rep_active_r <= 1'b0;
            rep_first_r  <= 1'b0;
        end else if (inc_press) begin
            rep_cnt_r    <= '0;
            rep_active_r <= 1'b1;
            rep_first_r  <= 1'b1;
        end else if (rep_active_r) begin
            if (rep_fire) begin
                rep_cnt_r   <= '0;
                rep_first_r <= 1'b0;
            end else begin
                rep_cnt_r <= rep_cnt_r + REP_ONE;
            end
        end else begin
            rep_cnt_r <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Blink phase: restarts dark on a state change, lit on an edit pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (mode_press || !in_set) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b0;
        end else if (inc_fire) begin
            blink_cnt_r <= '0;
            blink_r     <= 1'b1;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
        end
    end

    // Registered panel outputs decoded from the current state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode       <= 1'b1;
            set_field  <= FIELD_NONE;
            hour_set   <= 1'b0;
            minute_set <= 1'b0;
        end else begin
            mode       <= (state_r == TIMER);
            set_field  <= field_of(state_r);
            hour_set   <= inc_fire & (state_r == SET_HOUR);
            minute_set <= inc_fire & (state_r == SET_MINUTE);
        end
    end

    assign blink = blink_r;

endmodule
